// File: rtl/pc_pkg.sv
// Shared definitions for the program-counter unit: next-PC source encodings,
// default reset/exception vectors and the target alignment helper.
package pc_pkg;

    // Next-PC source select
    typedef enum logic [1:0] {
        SEL_INC    = 2'd0,
        SEL_BRANCH = 2'd1,
        SEL_JUMP   = 2'd2,
        SEL_JR     = 2'd3
    } pc_sel_e;

    localparam logic [31:0] DEF_RESET_VEC = 32'h0000_0000;
    localparam logic [31:0] DEF_EXC_VEC   = 32'h0000_0180;

    // Widest alignment field the helper accepts; callers zero-extend into it.
    localparam int ALIGN_MAX = 8;

    // A target is aligned when all of its low alignment bits are zero.
    function automatic logic is_aligned(input logic [ALIGN_MAX-1:0] low_bits);
        return (low_bits == '0);
    endfunction

endpackage

// File: rtl/pc_target.sv
// Next-PC target computation and misalignment check.
// Latency: purely combinational from pc and the current select/operand inputs.
// Backpressure: none; the caller decides whether the target is used.
module pc_target
    import pc_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int INC        = 4,
    parameter int ALIGN_BITS = 2,
    parameter int JIDX_W     = 26
) (
    input  logic [WIDTH-1:0]  pc,
    input  logic [1:0]        sel,
    input  logic [WIDTH-1:0]  br_off,
    input  logic [JIDX_W-1:0] j_index,
    input  logic [WIDTH-1:0]  jr_addr,
    output logic [WIDTH-1:0]  pc_inc,
    output logic [WIDTH-1:0]  target,
    output logic              misaligned
);

    logic [ALIGN_MAX-1:0] low_ext;

    // Sequential address; wraps silently modulo 2^WIDTH.
    assign pc_inc = pc + WIDTH'(INC);

    // Select the redirect target and flag it when its low bits are non-zero.
    // Only BRANCH and JR can produce a misaligned target; JUMP zero-fills the
    // low bits and INC is never treated as a redirect.
    always_comb begin
        target  = pc_inc;
        low_ext = '0;
        case (pc_sel_e'(sel))
            SEL_INC:    target = pc_inc;
            SEL_BRANCH: target = pc_inc + br_off;
            SEL_JUMP:   target = {pc_inc[WIDTH-1:JIDX_W+ALIGN_BITS], j_index,
                                  {ALIGN_BITS{1'b0}}};
            SEL_JR:     target = jr_addr;
        endcase
        low_ext[ALIGN_BITS-1:0] = target[ALIGN_BITS-1:0];
        misaligned = ((pc_sel_e'(sel) == SEL_BRANCH) || (pc_sel_e'(sel) == SEL_JR))
                     && !is_aligned(low_ext);
    end

endmodule

// File: rtl/pc_ctrl.sv
// Program counter with internal next-PC mux, redirect latch, EPC save/restore.
// Latency: one cycle; a request sampled at edge N is visible on pc_out after N.
// Backpressure: pc_we=0 holds the PC; redirects arriving then are latched (last wins).
module pc_ctrl
    import pc_pkg::*;
#(
    parameter int               WIDTH      = 32,
    parameter logic [WIDTH-1:0] RESET_VEC  = WIDTH'(DEF_RESET_VEC),
    parameter logic [WIDTH-1:0] EXC_VEC    = WIDTH'(DEF_EXC_VEC),
    parameter int               INC        = 4,
    parameter int               ALIGN_BITS = 2,
    parameter int               JIDX_W     = 26
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              pc_we,
    input  logic [1:0]        sel,
    input  logic [WIDTH-1:0]  br_off,
    input  logic [JIDX_W-1:0] j_index,
    input  logic [WIDTH-1:0]  jr_addr,
    input  logic              exc_req,
    input  logic              eret,
    output logic [WIDTH-1:0]  pc_out,
    output logic [WIDTH-1:0]  pc_inc,
    output logic [WIDTH-1:0]  epc_out,
    output logic              pend_valid,
    output logic              addr_err,
    output logic [WIDTH-1:0]  bad_addr
);

    logic [WIDTH-1:0] pc_q, pc_d;
    logic [WIDTH-1:0] epc_q, epc_d;
    logic [WIDTH-1:0] pend_tgt_q, pend_tgt_d;
    logic             pend_valid_q, pend_valid_d;
    logic             addr_err_q, addr_err_d;
    logic [WIDTH-1:0] bad_addr_q, bad_addr_d;

    logic [WIDTH-1:0] target;
    logic             misaligned;
    logic             redirect;

    pc_target #(
        .WIDTH      (WIDTH),
        .INC        (INC),
        .ALIGN_BITS (ALIGN_BITS),
        .JIDX_W     (JIDX_W)
    ) u_target (
        .pc         (pc_q),
        .sel        (sel),
        .br_off     (br_off),
        .j_index    (j_index),
        .jr_addr    (jr_addr),
        .pc_inc     (pc_inc),
        .target     (target),
        .misaligned (misaligned)
    );

    assign redirect = (pc_sel_e'(sel) != SEL_INC);

    // Priority resolution: exception, eret, rejected target, applied redirect,
    // sequential/pending step, latched redirect, hold.
    always_comb begin
        pc_d         = pc_q;
        epc_d        = epc_q;
        pend_tgt_d   = pend_tgt_q;
        pend_valid_d = pend_valid_q;
        addr_err_d   = 1'b0;
        bad_addr_d   = bad_addr_q;

        if (exc_req) begin
            epc_d        = pc_q;
            pc_d         = EXC_VEC;
            pend_valid_d = 1'b0;
        end else if (eret) begin
            pc_d         = epc_q;
            pend_valid_d = 1'b0;
        end else if (redirect && misaligned) begin
            // Rejected regardless of pc_we; PC and pending state are untouched.
            addr_err_d = 1'b1;
            bad_addr_d = target;
        end else if (pc_we && redirect) begin
            pc_d         = target;
            pend_valid_d = 1'b0;
        end else if (pc_we) begin
            if (pend_valid_q) begin
                pc_d         = pend_tgt_q;
                pend_valid_d = 1'b0;
            end else begin
                pc_d = pc_inc;
            end
        end else if (redirect) begin
            pend_tgt_d   = target;
            pend_valid_d = 1'b1;
        end
    end

    // State registers with asynchronous reset; reset discards any pending redirect.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q         <= RESET_VEC;
            epc_q        <= '0;
            pend_tgt_q   <= '0;
            pend_valid_q <= 1'b0;
            addr_err_q   <= 1'b0;
            bad_addr_q   <= '0;
        end else begin
            pc_q         <= pc_d;
            epc_q        <= epc_d;
            pend_tgt_q   <= pend_tgt_d;
            pend_valid_q <= pend_valid_d;
            addr_err_q   <= addr_err_d;
            bad_addr_q   <= bad_addr_d;
        end
    end

    assign pc_out     = pc_q;
    assign epc_out    = epc_q;
    assign pend_valid = pend_valid_q;
    assign addr_err   = addr_err_q;
    assign bad_addr   = bad_addr_q;

endmodule

// File: tb/tb_pc_ctrl.sv
// Self-checking bench for pc_ctrl: directed scenarios plus randomized traffic
// compared each cycle against a behavioural model of the PC rules.
module tb_pc_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        pc_we;
    logic [1:0]  sel;
    logic [31:0] br_off;
    logic [25:0] j_index;
    logic [31:0] jr_addr;
    logic        exc_req;
    logic        eret;
    logic [31:0] pc_out, pc_inc, epc_out, bad_addr;
    logic        pend_valid, addr_err;

    // 16-bit instance used for the wrap check
    logic        w_reset;
    logic        w_pc_we;
    logic [15:0] w_pc_out, w_pc_inc, w_epc_out, w_bad_addr;
    logic        w_pend_valid, w_addr_err;

    int checks   = 0;
    int failures = 0;

    // Behavioural model state
    logic [31:0] m_pc, m_epc, m_pt, m_bad;
    logic        m_pv, m_ae;

    always #5 clk = ~clk;

    pc_ctrl dut (
        .clk(clk), .reset(reset), .pc_we(pc_we), .sel(sel), .br_off(br_off),
        .j_index(j_index), .jr_addr(jr_addr), .exc_req(exc_req), .eret(eret),
        .pc_out(pc_out), .pc_inc(pc_inc), .epc_out(epc_out),
        .pend_valid(pend_valid), .addr_err(addr_err), .bad_addr(bad_addr)
    );

    pc_ctrl #(.WIDTH(16), .RESET_VEC(16'hFFFC), .EXC_VEC(16'h0180), .JIDX_W(8)) dut_w (
        .clk(clk), .reset(w_reset), .pc_we(w_pc_we), .sel(2'd0), .br_off(16'h0),
        .j_index(8'h0), .jr_addr(16'h0), .exc_req(1'b0), .eret(1'b0),
        .pc_out(w_pc_out), .pc_inc(w_pc_inc), .epc_out(w_epc_out),
        .pend_valid(w_pend_valid), .addr_err(w_addr_err), .bad_addr(w_bad_addr)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pc = 32'h0; m_epc = 32'h0; m_pt = 32'h0; m_bad = 32'h0;
        m_pv = 1'b0;  m_ae = 1'b0;
    endtask

    // Apply the spec's per-edge rules to the model for the given inputs.
    task automatic model_edge(input logic we, input logic [1:0] s, input logic [31:0] br,
                              input logic [25:0] ji, input logic [31:0] jr,
                              input logic ex, input logic er);
        logic [31:0] nxt, tgt;
        logic        mis;
        nxt = m_pc + 32'd4;
        case (s)
            2'd1:    tgt = nxt + br;
            2'd2:    tgt = (nxt & 32'hF000_0000) | ({6'd0, ji} * 32'd4);
            2'd3:    tgt = jr;
            default: tgt = nxt;
        endcase
        mis  = (s == 2'd1 || s == 2'd3) && ((tgt % 32'd4) != 32'd0);
        m_ae = 1'b0;
        if (ex) begin
            m_epc = m_pc; m_pc = 32'h180; m_pv = 1'b0;
        end else if (er) begin
            m_pc = m_epc; m_pv = 1'b0;
        end else if (s != 2'd0 && mis) begin
            m_ae = 1'b1; m_bad = tgt;
        end else if (we && s != 2'd0) begin
            m_pc = tgt; m_pv = 1'b0;
        end else if (we) begin
            if (m_pv) begin m_pc = m_pt; m_pv = 1'b0; end
            else m_pc = nxt;
        end else if (s != 2'd0) begin
            m_pt = tgt; m_pv = 1'b1;
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".pc_out"},     pc_out,             m_pc);
        check({tag, ".pc_inc"},     pc_inc,             m_pc + 32'd4);
        check({tag, ".epc_out"},    epc_out,            m_epc);
        check({tag, ".pend_valid"}, {31'd0, pend_valid}, {31'd0, m_pv});
        check({tag, ".addr_err"},   {31'd0, addr_err},   {31'd0, m_ae});
        check({tag, ".bad_addr"},   bad_addr,           m_bad);
    endtask

    // Drive one cycle of inputs, advance model and DUT, compare everything.
    task automatic step(input string tag, input logic we, input logic [1:0] s,
                        input logic [31:0] br, input logic [25:0] ji, input logic [31:0] jr,
                        input logic ex, input logic er);
        pc_we = we; sel = s; br_off = br; j_index = ji; jr_addr = jr;
        exc_req = ex; eret = er;
        model_edge(we, s, br, ji, jr, ex, er);
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    initial begin
        logic [31:0] rb, rj;
        logic [1:0]  rs;
        reset = 1'b1; w_reset = 1'b1;
        pc_we = 1'b0; sel = 2'd0; br_off = '0; j_index = '0; jr_addr = '0;
        exc_req = 1'b0; eret = 1'b0; w_pc_we = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        check("w_reset.pc_out", {16'd0, w_pc_out}, 32'h0000_FFFC);
        check("w_reset.pc_inc", {16'd0, w_pc_inc}, 32'h0000_0000);
        check("w_reset.epc", {16'd0, w_epc_out}, 32'h0);
        check("w_reset.flags", {16'd0, w_bad_addr} | {30'd0, w_pend_valid, w_addr_err}, 32'h0);

        // 16-bit wrap: one INC from 0xFFFC lands on 0x0000
        w_reset = 1'b0; w_pc_we = 1'b1;
        @(posedge clk);
        #1;
        w_pc_we = 1'b0;
        check("w_wrap.pc_out", {16'd0, w_pc_out}, 32'h0000_0000);
        check("w_wrap.pc_inc", {16'd0, w_pc_inc}, 32'h0000_0004);

        // Sequential stepping
        reset = 1'b0;
        step("inc1", 1, 2'd0, 0, 0, 0, 0, 0);
        check("inc1.val", pc_out, 32'h4);
        step("inc2", 1, 2'd0, 0, 0, 0, 0, 0);
        step("inc3", 1, 2'd0, 0, 0, 0, 0, 0);
        check("inc3.val", pc_out, 32'hC);

        // Latch a redirect, then reset between edges: immediate and discards it
        step("latch_pre_rst", 0, 2'd3, 0, 0, 32'h3000, 0, 0);
        check("latch_pre_rst.pv", {31'd0, pend_valid}, 32'h1);
        #2 reset = 1'b1;
        #1;
        model_reset();
        check("async_rst.pc_out", pc_out, 32'h0);
        check("async_rst.pend", {31'd0, pend_valid}, 32'h0);
        #1 reset = 1'b0;
        step("post_rst", 1, 2'd0, 0, 0, 0, 0, 0);
        check("post_rst.val", pc_out, 32'h4);

        // Branch with negative offset, then jump
        step("jr_100", 1, 2'd3, 0, 0, 32'h100, 0, 0);
        step("branch", 1, 2'd1, 32'hFFFF_FFF0, 0, 0, 0, 0);
        check("branch.val", pc_out, 32'hF4);
        step("jump", 1, 2'd2, 0, 26'h40, 0, 0, 0);
        check("jump.val", pc_out, 32'h100);

        // Pending redirect applied on next enabled INC
        step("pend_jr", 0, 2'd3, 0, 0, 32'h2000, 0, 0);
        check("pend_jr.hold", pc_out, 32'h100);
        step("pend_apply", 1, 2'd0, 0, 0, 0, 0, 0);
        check("pend_apply.val", pc_out, 32'h2000);
        // Pending redirect superseded by a fresh branch
        step("pend_jr2", 0, 2'd3, 0, 0, 32'h5000, 0, 0);
        step("pend_supersede", 1, 2'd1, 32'h10, 0, 0, 0, 0);
        check("pend_supersede.val", pc_out, 32'h2014);
        step("after_supersede", 1, 2'd0, 0, 0, 0, 0, 0);
        check("after_supersede.val", pc_out, 32'h2018);

        // Exception, eret, and simultaneous exc+eret
        step("jr_40", 1, 2'd3, 0, 0, 32'h40, 0, 0);
        step("exc", 1, 2'd3, 0, 0, 32'h500, 1, 0);
        check("exc.pc", pc_out, 32'h180);
        check("exc.epc", epc_out, 32'h40);
        step("eret", 0, 2'd0, 0, 0, 0, 0, 1);
        check("eret.pc", pc_out, 32'h40);
        step("exc_eret", 0, 2'd0, 0, 0, 0, 1, 1);
        check("exc_eret.pc", pc_out, 32'h180);

        // Misaligned JR: rejected, one-cycle addr_err pulse
        step("mis_jr", 1, 2'd3, 0, 0, 32'h1002, 0, 0);
        check("mis_jr.pc", pc_out, 32'h180);
        check("mis_jr.err", {31'd0, addr_err}, 32'h1);
        check("mis_jr.bad", bad_addr, 32'h1002);
        step("mis_clear", 0, 2'd0, 0, 0, 0, 0, 0);
        check("mis_clear.err", {31'd0, addr_err}, 32'h0);

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            rs = 2'($urandom_range(0, 3));
            rb = $urandom & 32'h0000_FFFC;
            if ($urandom_range(0, 7) == 0) rb = rb | 32'h2;
            if ($urandom_range(0, 1) == 0) rb = -rb;
            rj = $urandom & 32'hFFFF_FFFC;
            if ($urandom_range(0, 7) == 0) rj = rj | 32'($urandom_range(1, 3));
            step("rand", 1'($urandom_range(0, 1)), rs, rb, 26'($urandom), rj,
                 ($urandom_range(0, 15) == 0), ($urandom_range(0, 15) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
